// File: rtl/ibex_rf_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter and its load-data FIFO.
// Optional feature macro: IBEX_RF_ARB_LSU_BYPASS_EN (see ibex_rf_wport_arbiter.sv).
package ibex_rf_wport_arbiter_pkg;

   typedef enum logic [1:0] {
      RF_ARB_NONE = 2'd0,
      RF_ARB_LSU  = 2'd1,
      RF_ARB_ID   = 2'd2,
      RF_ARB_EXT  = 2'd3
   } rf_arb_src_e;

   typedef struct packed {
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } rf_wr_req_t;

endpackage

// File: rtl/ibex_rf_wport_arbiter_if.sv
// Bundle of writer handshakes, hazard-check addresses and RF write port around the arbiter.
// master = writeback/LSU/EXT/RF side, slave = the arbiter.
interface ibex_rf_wport_arbiter_if;

   logic        rf_wport_stall_i;
   logic        id_valid_i;
   logic        id_ready_o;
   logic [4:0]  id_waddr_i;
   logic [31:0] id_wdata_i;
   logic        lsu_we_i;
   logic [4:0]  lsu_waddr_i;
   logic [31:0] lsu_wdata_i;
   logic        lsu_full_o;
   logic        ext_valid_i;
   logic        ext_ready_o;
   logic [4:0]  ext_waddr_i;
   logic [31:0] ext_wdata_i;
   logic [4:0]  rf_raddr_a_i;
   logic [4:0]  rf_raddr_b_i;
   logic        rf_rd_hazard_o;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        lsu_overflow_o;

   modport master (
      output rf_wport_stall_i, id_valid_i, id_waddr_i, id_wdata_i,
             lsu_we_i, lsu_waddr_i, lsu_wdata_i,
             ext_valid_i, ext_waddr_i, ext_wdata_i, rf_raddr_a_i, rf_raddr_b_i,
      input  id_ready_o, lsu_full_o, ext_ready_o, rf_rd_hazard_o,
             rf_we_o, rf_waddr_o, rf_wdata_o, lsu_overflow_o
   );

   modport slave (
      input  rf_wport_stall_i, id_valid_i, id_waddr_i, id_wdata_i,
             lsu_we_i, lsu_waddr_i, lsu_wdata_i,
             ext_valid_i, ext_waddr_i, ext_wdata_i, rf_raddr_a_i, rf_raddr_b_i,
      output id_ready_o, lsu_full_o, ext_ready_o, rf_rd_hazard_o,
             rf_we_o, rf_waddr_o, rf_wdata_o, lsu_overflow_o
   );

endinterface

// File: rtl/ibex_rf_wport_arbiter_fifo.sv
// ibex_rf_wr_fifo: synchronous FIFO for load write-backs with sticky overflow and per-entry
// valid/waddr taps used by the read-after-write hazard compare.
module ibex_rf_wr_fifo
   import ibex_rf_wport_arbiter_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter type         req_t = rf_wr_req_t
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             i_push,
   input  logic             i_pop,
   input  req_t             i_wdata,
   output req_t             o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_overflow,
   output logic [Depth-1:0] o_valid,
   output logic [4:0]       o_waddr [Depth]
);

   localparam int unsigned    PtrW    = $clog2(Depth);
   localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

   logic [PtrW-1:0] r_wptr, r_rptr;
   logic [PtrW:0]   r_count;
   logic            r_overflow;
   req_t            r_mem [Depth];
   logic            w_push_ok, w_pop_ok;

   assign o_full     = (r_count == FullCnt);
   assign o_empty    = (r_count == '0);
   assign o_overflow = r_overflow;
   assign o_rdata    = r_mem[r_rptr];

   // A push into a full FIFO is only kept when the head leaves in the same cycle.
   assign w_push_ok = i_push & (~o_full | i_pop);
   assign w_pop_ok  = i_pop & ~o_empty;

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
         unique case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (i_push && o_full && !i_pop) r_overflow <= 1'b1;
      end
   end

   // NOTE: storage is not reset; occupancy is tracked by pointers/count, which are.
   always_ff @(posedge clk_i) begin
      if (w_push_ok) r_mem[r_wptr] <= i_wdata;
   end

   for (genvar i = 0; i < Depth; i++) begin : g_tap
      logic [PtrW-1:0] w_off;
      assign w_off      = PtrW'(i) - r_rptr;
      assign o_valid[i] = ({1'b0, w_off} < r_count);
      assign o_waddr[i] = r_mem[i].waddr;
   end

endmodule

// File: rtl/ibex_rf_wport_arbiter.sv
// Register-file write-port arbiter: LSU FIFO head > starved EXT > ID/EX > EXT.
// Build option IBEX_RF_ARB_LSU_BYPASS_EN lets a load into an empty FIFO write in the same cycle.
module ibex_rf_wport_arbiter
   import ibex_rf_wport_arbiter_pkg::*;
#(
   parameter int unsigned LsuDepth = 4,
   parameter int unsigned MaxWait  = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   ibex_rf_wport_arbiter_if.slave   bus
);

   localparam int unsigned    WaitW   = $clog2(MaxWait + 1);
   localparam logic [WaitW-1:0] WaitMax = WaitW'(MaxWait);

   logic [WaitW-1:0] r_wait_cnt;
   rf_arb_src_e      w_src;
   rf_wr_req_t       w_lsu_req, w_head, w_req;
   logic             w_empty, w_full, w_overflow, w_bypass, w_push, w_pop, w_hazard;
   logic [LsuDepth-1:0] w_valid;
   logic [4:0]       w_ent_waddr [LsuDepth];

   assign w_lsu_req = '{waddr: bus.lsu_waddr_i, wdata: bus.lsu_wdata_i};

`ifdef IBEX_RF_ARB_LSU_BYPASS_EN
   assign w_bypass = ~rst_i & ~bus.rf_wport_stall_i & w_empty & bus.lsu_we_i;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push = bus.lsu_we_i & ~w_bypass;
   assign w_pop  = (w_src == RF_ARB_LSU) & ~w_empty;

   ibex_rf_wr_fifo #(
      .Depth (LsuDepth),
      .req_t (rf_wr_req_t)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_push     (w_push),
      .i_pop      (w_pop),
      .i_wdata    (w_lsu_req),
      .o_rdata    (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_overflow (w_overflow),
      .o_valid    (w_valid),
      .o_waddr    (w_ent_waddr)
   );

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_src = RF_ARB_NONE;
      if (!rst_i && !bus.rf_wport_stall_i) begin
         if (!w_empty || w_bypass)                           w_src = RF_ARB_LSU;
         else if (bus.ext_valid_i && r_wait_cnt == WaitMax)  w_src = RF_ARB_EXT;
         else if (bus.id_valid_i)                            w_src = RF_ARB_ID;
         else if (bus.ext_valid_i)                           w_src = RF_ARB_EXT;
      end
   end

   always_comb begin
      w_req = '0;
      unique case (w_src)
         RF_ARB_LSU: w_req = w_empty ? w_lsu_req : w_head;
         RF_ARB_ID:  w_req = '{waddr: bus.id_waddr_i, wdata: bus.id_wdata_i};
         RF_ARB_EXT: w_req = '{waddr: bus.ext_waddr_i, wdata: bus.ext_wdata_i};
         default:    w_req = '0;
      endcase
   end

   assign bus.rf_we_o     = (w_src != RF_ARB_NONE);
   assign bus.rf_waddr_o  = w_req.waddr;
   assign bus.rf_wdata_o  = w_req.wdata;
   assign bus.id_ready_o  = (w_src == RF_ARB_ID);
   assign bus.ext_ready_o = (w_src == RF_ARB_EXT);

   // Refusal counter: lets EXT overtake ID once it has been starved MaxWait cycles.
   always_ff @(posedge clk_i) begin
      if (rst_i)                                    r_wait_cnt <= '0;
      else if (!bus.ext_valid_i || bus.ext_ready_o) r_wait_cnt <= '0;
      else if (r_wait_cnt != WaitMax)               r_wait_cnt <= r_wait_cnt + 1'b1;
   end

   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < LsuDepth; i++) begin
         if (w_valid[i] &&
             ((w_ent_waddr[i] == bus.rf_raddr_a_i && bus.rf_raddr_a_i != 5'd0) ||
              (w_ent_waddr[i] == bus.rf_raddr_b_i && bus.rf_raddr_b_i != 5'd0)))
            w_hazard = 1'b1;
      end
   end

   assign bus.rf_rd_hazard_o = w_hazard & ~rst_i;
   assign bus.lsu_full_o     = w_full & ~rst_i;
   assign bus.lsu_overflow_o = w_overflow & ~rst_i;

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
// Directed bench for ibex_rf_wport_arbiter (LsuDepth=4, MaxWait=8); honours
// IBEX_RF_ARB_LSU_BYPASS_EN when choosing the expected load write-back timing.
module tb_ibex_rf_wport_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   ibex_rf_wport_arbiter_if bus ();

   ibex_rf_wport_arbiter #(
      .LsuDepth (4),
      .MaxWait  (8)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled mid-cycle.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.rf_wport_stall_i = 1'b0;
      bus.id_valid_i  = 1'b0; bus.id_waddr_i  = '0; bus.id_wdata_i  = '0;
      bus.lsu_we_i    = 1'b0; bus.lsu_waddr_i = '0; bus.lsu_wdata_i = '0;
      bus.ext_valid_i = 1'b0; bus.ext_waddr_i = '0; bus.ext_wdata_i = '0;
      bus.rf_raddr_a_i = '0;  bus.rf_raddr_b_i = '0;
   endtask

   logic [4:0] push_addr [4];

   initial begin
      push_addr[0] = 5'd7; push_addr[1] = 5'd0; push_addr[2] = 5'd9; push_addr[3] = 5'd10;
      idle();

      // Reset with busy inputs: nothing may leak out
      bus.id_valid_i = 1'b1; bus.lsu_we_i = 1'b1; bus.ext_valid_i = 1'b1;
      #1;
      check("rst_we", bus.rf_we_o, 0);
      check("rst_id_ready", bus.id_ready_o, 0);
      check("rst_ext_ready", bus.ext_ready_o, 0);
      check("rst_full", bus.lsu_full_o, 0);
      check("rst_ovf", bus.lsu_overflow_o, 0);
      cyc(); cyc();
      rst = 1'b0; idle();

      // 1. ID alone writes in the same cycle
      bus.id_valid_i = 1'b1; bus.id_waddr_i = 5'd5; bus.id_wdata_i = 32'hA5;
      #1;
      check("t1_id_ready", bus.id_ready_o, 1);
      check("t1_we", bus.rf_we_o, 1);
      check("t1_waddr", bus.rf_waddr_o, 5);
      check("t1_wdata", bus.rf_wdata_o, 32'hA5);
      cyc();

      // 2. Stalled port: four loads buffered, ID held off
      bus.rf_wport_stall_i = 1'b1;
      bus.id_waddr_i = 5'd20; bus.id_wdata_i = 32'h20;
      for (int i = 0; i < 4; i++) begin
         bus.lsu_we_i = 1'b1; bus.lsu_waddr_i = push_addr[i]; bus.lsu_wdata_i = 32'h100 + i;
         #1;
         check("t2_stall_we", bus.rf_we_o, 0);
         check("t2_stall_id", bus.id_ready_o, 0);
         check("t2_full_pre", bus.lsu_full_o, 0);
         cyc();
      end
      check("t2_full", bus.lsu_full_o, 1);
      check("t2_no_ovf", bus.lsu_overflow_o, 0);

      // 3. Fifth push while full and stalled is dropped and flagged
      bus.lsu_waddr_i = 5'd3; bus.lsu_wdata_i = 32'hDEAD;
      cyc();
      bus.lsu_we_i = 1'b0;
      #1;
      check("t3_ovf", bus.lsu_overflow_o, 1);
      check("t3_full", bus.lsu_full_o, 1);

      // 5. Hazard against buffered loads
      bus.rf_raddr_a_i = 5'd7; #1;
      check("t5_haz_x7", bus.rf_rd_hazard_o, 1);
      bus.rf_raddr_a_i = 5'd0; #1;
      check("t5_haz_x0", bus.rf_rd_hazard_o, 0);
      bus.rf_raddr_b_i = 5'd10; #1;
      check("t5_haz_b", bus.rf_rd_hazard_o, 1);
      bus.rf_raddr_b_i = 5'd3; #1;
      check("t5_haz_dropped", bus.rf_rd_hazard_o, 0);
      bus.rf_raddr_b_i = 5'd0;

      // 2/3 continued: unstall drains loads in push order ahead of ID
      bus.rf_wport_stall_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t2_drain_we", bus.rf_we_o, 1);
         check("t2_drain_waddr", bus.rf_waddr_o, push_addr[i]);
         check("t2_drain_wdata", bus.rf_wdata_o, 32'h100 + i);
         check("t2_drain_id", bus.id_ready_o, 0);
         cyc();
      end
      check("t2_after_full", bus.lsu_full_o, 0);
      check("t2_id_ready", bus.id_ready_o, 1);
      check("t2_id_waddr", bus.rf_waddr_o, 20);
      check("t3_ovf_held", bus.lsu_overflow_o, 1);
      cyc();
      idle();

      // Overflow clears only on reset
      rst = 1'b1; cyc();
      rst = 1'b0; #1;
      check("t3_ovf_cleared", bus.lsu_overflow_o, 0);
      check("t3_empty_after_rst", bus.rf_we_o, 0);

      // 4. ID and EXT both valid: EXT wins on the 9th cycle
      bus.id_valid_i = 1'b1;  bus.id_waddr_i  = 5'd1; bus.id_wdata_i  = 32'h11;
      bus.ext_valid_i = 1'b1; bus.ext_waddr_i = 5'd2; bus.ext_wdata_i = 32'hE0;
      for (int c = 1; c <= 10; c++) begin
         #1;
         if (c == 9) begin
            check("t4_ext_ready", bus.ext_ready_o, 1);
            check("t4_ext_id", bus.id_ready_o, 0);
            check("t4_ext_waddr", bus.rf_waddr_o, 2);
            check("t4_ext_wdata", bus.rf_wdata_o, 32'hE0);
         end else begin
            check("t4_id_ready", bus.id_ready_o, 1);
            check("t4_id_ext", bus.ext_ready_o, 0);
         end
         cyc();
      end
      idle();
      cyc();

      // 6. Load return with ID request on an empty FIFO
      bus.lsu_we_i = 1'b1; bus.lsu_waddr_i = 5'd4; bus.lsu_wdata_i = 32'h44;
      bus.id_valid_i = 1'b1; bus.id_waddr_i = 5'd6; bus.id_wdata_i = 32'h66;
      #1;
`ifdef IBEX_RF_ARB_LSU_BYPASS_EN
      check("t6_byp_we", bus.rf_we_o, 1);
      check("t6_byp_waddr", bus.rf_waddr_o, 4);
      check("t6_byp_wdata", bus.rf_wdata_o, 32'h44);
      check("t6_byp_id", bus.id_ready_o, 0);
      cyc();
      bus.lsu_we_i = 1'b0; #1;
      check("t6_byp_id_next", bus.id_ready_o, 1);
      check("t6_byp_id_waddr", bus.rf_waddr_o, 6);
`else
      check("t6_id_first", bus.id_ready_o, 1);
      check("t6_id_waddr", bus.rf_waddr_o, 6);
      check("t6_id_wdata", bus.rf_wdata_o, 32'h66);
      cyc();
      bus.lsu_we_i = 1'b0; #1;
      check("t6_lsu_we", bus.rf_we_o, 1);
      check("t6_lsu_waddr", bus.rf_waddr_o, 4);
      check("t6_lsu_wdata", bus.rf_wdata_o, 32'h44);
      check("t6_lsu_id", bus.id_ready_o, 0);
`endif
      cyc();
      idle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
